// File: rtl/logger_pkg.sv
// ============================================================================
// Module : logger_pkg
// Brief  : Shared widths and FSM state encoding for the sensor data-RAM logger.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package logger_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WR_SAMPLE = 2'd1,
        S_WR_PTR    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchronizer for a bus of independent asynchronous bits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/sensor_dmem_logger.sv
// ============================================================================
// Module : sensor_dmem_logger
// Brief  : Periodically samples eight board inputs into a RAM ring buffer,
//          sharing the RAM port with the CPU (CPU always wins).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sensor_dmem_logger
    import logger_pkg::*;
#(
    parameter int          SAMPLE_PERIOD = 1000,
    parameter logic [11:0] BASE_ADDR     = 12'h800,
    parameter int          DEPTH         = 256,
    parameter logic [11:0] PTR_ADDR      = 12'h7FF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [BYTE_W-1:0] in_bits,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic              overrun_clr,
    output logic              busy,
    output logic              overrun
);

    localparam int                 c_CNT_W     = $clog2(SAMPLE_PERIOD);
    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [c_PTR_W-1:0] c_WPTR_LAST = c_PTR_W'(DEPTH - 1);

    logic [c_CNT_W-1:0] r_tick_cnt;
    logic               w_tick;
    logic [BYTE_W-1:0]  w_synced;
    logic [BYTE_W-1:0]  r_sample;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] w_wptr_nxt;
    logic               r_wrapped;
    logic               w_wrapped_nxt;
    logic               w_ptr_commit;
    logic               r_overrun;

    sync_2ff #(
        .WIDTH (BYTE_W)
    ) u_sync (
        .clk (clock),
        .rst (reset),
        .i_d (in_bits),
        .o_q (w_synced)
    );

    assign w_tick        = enable && (r_tick_cnt == c_TICK_LAST);
    assign w_wptr_nxt    = r_wptr + 1'b1;
    assign w_wrapped_nxt = r_wrapped | (r_wptr == c_WPTR_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sample  <= '0;
            r_wptr    <= '0;
            r_wrapped <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tick && r_state == S_IDLE) begin
                r_sample <= w_synced;
            end
            if (w_ptr_commit) begin
                r_wptr    <= w_wptr_nxt;
                r_wrapped <= w_wrapped_nxt;
            end
            // A drop in the same cycle as a clear must leave overrun set.
            if (w_tick && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // The CPU owns the port whenever it asks; the logger only advances on free cycles.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_commit = 1'b0;
        ram_wEn      = cpu_req & cpu_wren;
        ram_addr     = cpu_addr;
        ram_dataIn   = cpu_data;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = S_WR_SAMPLE;
                end
            end
            S_WR_SAMPLE: begin
                if (!cpu_req) begin
                    ram_wEn     = 1'b1;
                    ram_addr    = BASE_ADDR + ADDR_W'(r_wptr);
                    ram_dataIn  = {{(DATA_W-BYTE_W){1'b0}}, r_sample};
                    w_state_nxt = S_WR_PTR;
                end
            end
            S_WR_PTR: begin
                if (!cpu_req) begin
                    ram_wEn      = 1'b1;
                    ram_addr     = PTR_ADDR;
                    ram_dataIn   = {w_wrapped_nxt, {(DATA_W-1-ADDR_W){1'b0}}, ADDR_W'(w_wptr_nxt)};
                    w_ptr_commit = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign overrun = r_overrun;

endmodule

`default_nettype wire
